io_controller: RTL and testbench

//  Device end of the core's IN/OUT instruction protocol: services out_issued/out_data and in_issued/in_data,

---
 rtl/io_ctrl_pkg.sv | 19 +
 rtl/io_byte_fifo.sv | 65 ++++++
 rtl/io_controller.sv | 156 +++++++++++++++
 tb/tb_io_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared types and helpers for the IN/OUT device controller and its byte FIFOs.
package io_ctrl_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } tx_state_t;

   // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
   function automatic int clog2p1(input int depth);
      int w;
      w = 0;
      for (int v = depth - 1; v > 0; v = v >> 1) w++;
      return w + 1;
   endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with show-ahead heads (head0 = oldest) and a pop that removes POP_N bytes at once.
// A push is accepted while full only when a pop frees space in the same cycle.
module io_byte_fifo
   import io_ctrl_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int POP_N = 1
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [7:0]                  push_data,
   input  logic                        pop,
   output logic                        full,
   output logic                        empty,
   output logic [clog2p1(DEPTH)-1:0]   count,
   output logic [7:0]                  head0,
   output logic [7:0]                  head1,
   output logic [7:0]                  head2,
   output logic [7:0]                  head3
);

   localparam int PW = clog2p1(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   byte_t         mem [DEPTH];
   byte_t         head_arr [4];
   logic          push_ok;

   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(POP_N);
      end
   end

   // Storage carries no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_head
      logic [AW-1:0] idx;
      assign idx          = rd_ptr_reg[AW-1:0] + AW'(gi);
      assign head_arr[gi] = mem[idx];
   end

   assign head0 = head_arr[0];
   assign head1 = head_arr[1];
   assign head2 = head_arr[2];
   assign head3 = head_arr[3];

endmodule

// File: rtl/io_controller.sv
// Device end of the core's IN/OUT protocol: TX FIFO feeding a UART transmitter, RX FIFO fed by a UART receiver.
// Optional IO_CTRL_LOOPBACK_EN adds a loopback input that routes OUT bytes straight into the RX FIFO.
module io_controller
   import io_ctrl_pkg::*;
#(
   parameter int TX_DEPTH = 64,
   parameter int RX_DEPTH = 64,
   parameter int IN_BYTES = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        out_issued,
   input  logic [31:0] out_data,
   output logic        out_stall,
   input  logic        in_issued,
   output logic [31:0] in_data,
   output logic        in_stall,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        rx_overflow
`ifdef IO_CTRL_LOOPBACK_EN
   ,
   input  logic        loopback
`endif
);

   localparam int TXW = clog2p1(TX_DEPTH);
   localparam int RXW = clog2p1(RX_DEPTH);

   logic           tx_push, tx_pop, tx_full, tx_empty;
   logic [TXW-1:0] tx_count;
   logic [7:0]     tx_head0, tx_head1, tx_head2, tx_head3;
   logic           rx_push, rx_full, rx_empty;
   logic [RXW-1:0] rx_count;
   logic [7:0]     rx_head0, rx_head1, rx_head2, rx_head3;
   logic           out_accept, in_pop, rx_drop;
   logic [31:0]    in_word;

   tx_state_t      state_reg;
   logic [7:0]     tx_byte_reg;
   logic           tx_valid_reg;
   logic           rx_overflow_reg;

   assign out_accept = out_issued && !out_stall;
   assign in_stall   = (rx_count < RXW'(IN_BYTES));
   assign in_pop     = in_issued && !in_stall;

`ifdef IO_CTRL_LOOPBACK_EN
   assign out_stall = loopback ? rx_full : tx_full;
   assign tx_push   = out_accept && !loopback;
   assign rx_push   = loopback ? out_accept : rx_valid;
   assign rx_drop   = !loopback && rx_valid && rx_full && !in_pop;
`else
   assign out_stall = tx_full;
   assign tx_push   = out_accept;
   assign rx_push   = rx_valid;
   assign rx_drop   = rx_valid && rx_full && !in_pop;
`endif

   io_byte_fifo #(.DEPTH(TX_DEPTH), .POP_N(1)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (out_data[7:0]),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count),
      .head0     (tx_head0),
      .head1     (tx_head1),
      .head2     (tx_head2),
      .head3     (tx_head3)
   );

   io_byte_fifo #(.DEPTH(RX_DEPTH), .POP_N(IN_BYTES)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_push),
      .push_data (rx_byte_mux()),
      .pop       (in_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count),
      .head0     (rx_head0),
      .head1     (rx_head1),
      .head2     (rx_head2),
      .head3     (rx_head3)
   );

   function automatic logic [7:0] rx_byte_mux();
`ifdef IO_CTRL_LOOPBACK_EN
      return loopback ? out_data[7:0] : rx_byte;
`else
      return rx_byte;
`endif
   endfunction

   // Show-ahead IN result: head0 is the oldest byte and lands in the low byte.
   if (IN_BYTES == 4) begin : g_word
      assign in_word = {rx_head3, rx_head2, rx_head1, rx_head0};
   end else begin : g_byte
      assign in_word = {24'b0, rx_head0};
   end

   assign in_data = in_stall ? 32'b0 : in_word;

   // The holding register is reloaded only when it is empty or being accepted, so a
   // stalled byte stays put and back-to-back bytes flow without a bubble.
   assign tx_pop = !tx_empty && ((state_reg == IDLE) || tx_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         tx_byte_reg  <= '0;
         tx_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!tx_empty) begin
                  tx_byte_reg  <= tx_head0;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= LOAD;
               end
            end
            LOAD: begin
               if (tx_ready) begin
                  if (!tx_empty) begin
                     tx_byte_reg <= tx_head0;
                  end else begin
                     tx_valid_reg <= 1'b0;
                     state_reg    <= IDLE;
                  end
               end
            end
            default: begin
               tx_valid_reg <= 1'b0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rx_overflow_reg <= 1'b0;
      else if (rx_drop) rx_overflow_reg <= 1'b1;
   end

   assign tx_byte     = tx_byte_reg;
   assign tx_valid    = tx_valid_reg;
   assign rx_overflow = rx_overflow_reg;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller (IN_BYTES=4): queue-based model checked every cycle plus directed literals.
// Loopback scenario is exercised when IO_CTRL_LOOPBACK_EN is defined.
module tb_io_controller;

   localparam int TXD = 64;
   localparam int RXD = 64;
   localparam int INB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_issued, in_issued, rx_valid, tx_ready, loopback;
   logic [31:0] out_data;
   logic [7:0]  rx_byte;
   logic        out_stall, in_stall, tx_valid, rx_overflow;
   logic [31:0] in_data;
   logic [7:0]  tx_byte;

   int checks = 0;
   int passed = 0;
   int accepted;

   always #5 clk = ~clk;

   io_controller #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .IN_BYTES(INB)) dut (
      .clk         (clk),
      .rst         (rst),
      .out_issued  (out_issued),
      .out_data    (out_data),
      .out_stall   (out_stall),
      .in_issued   (in_issued),
      .in_data     (in_data),
      .in_stall    (in_stall),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .tx_byte     (tx_byte),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_overflow (rx_overflow)
`ifdef IO_CTRL_LOOPBACK_EN
      ,
      .loopback    (loopback)
`endif
   );

   // ---------------- behavioural model ----------------
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic       hold_v;
   logic [7:0] hold_b;
   logic       ovf;
   logic       m_acc_out, m_acc_in;

   function automatic logic m_out_stall();
      return loopback ? (rxq.size() == RXD) : (txq.size() == TXD);
   endfunction

   function automatic logic m_in_stall();
      return rxq.size() < INB;
   endfunction

   function automatic logic [31:0] m_in_data();
      logic [31:0] d;
      d = '0;
      if (rxq.size() < INB) return '0;
      for (int k = 0; k < INB; k++) d = d | (32'(rxq[k]) << (8 * k));
      return d;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         txq.delete();
         rxq.delete();
         hold_v = 1'b0;
         hold_b = 8'h00;
         ovf    = 1'b0;
      end else begin
         m_acc_out = out_issued && !m_out_stall();
         m_acc_in  = in_issued && !m_in_stall();
         if (!hold_v || tx_ready) begin
            if (txq.size() > 0) begin
               hold_b = txq.pop_front();
               hold_v = 1'b1;
            end else begin
               hold_v = 1'b0;
            end
         end
         if (m_acc_out && !loopback) txq.push_back(out_data[7:0]);
         if (m_acc_in) for (int k = 0; k < INB; k++) void'(rxq.pop_front());
         if (loopback) begin
            if (m_acc_out) rxq.push_back(out_data[7:0]);
         end else if (rx_valid) begin
            if (rxq.size() < RXD) rxq.push_back(rx_byte);
            else                  ovf = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("out_stall", {31'b0, out_stall}, {31'b0, m_out_stall()});
         chk("in_stall", {31'b0, in_stall}, {31'b0, m_in_stall()});
         chk("in_data", in_data, m_in_data());
         chk("tx_valid", {31'b0, tx_valid}, {31'b0, hold_v});
         if (hold_v) chk("tx_byte", {24'b0, tx_byte}, {24'b0, hold_b});
         chk("rx_overflow", {31'b0, rx_overflow}, {31'b0, ovf});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      out_issued = 1'b0;
      in_issued  = 1'b0;
      rx_valid   = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      step();
   endtask

   task automatic do_out(input logic [31:0] d);
      out_issued = 1'b1;
      out_data   = d;
      step();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_out_stall"}, {31'b0, out_stall}, 32'd0);
      chk({tag, "_in_stall"}, {31'b0, in_stall}, 32'd1);
      chk({tag, "_in_data"}, in_data, 32'd0);
      chk({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
      chk({tag, "_tx_byte"}, {24'b0, tx_byte}, 32'd0);
      chk({tag, "_rx_overflow"}, {31'b0, rx_overflow}, 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      out_issued = 1'b0;
      in_issued  = 1'b0;
      rx_valid   = 1'b0;
      tx_ready   = 1'b0;
      loopback   = 1'b0;
      out_data   = '0;
      rx_byte    = '0;
      #3;
      check_reset_values("reset");
      #20 rst = 1'b0;
      step();

      // Two OUTs drain back-to-back with tx_ready held high.
      tx_ready = 1'b1;
      do_out(32'hFFFF_FF41);
      do_out(32'h0000_0042);
      chk("t1_byte0", {23'b0, tx_valid, tx_byte}, 32'h0000_0141);
      step();
      chk("t1_byte1", {23'b0, tx_valid, tx_byte}, 32'h0000_0142);
      step();
      chk("t1_idle", {31'b0, tx_valid}, 32'd0);

      // Word IN: stalled until four bytes are buffered.
      rx_push(8'h11);
      rx_push(8'h22);
      rx_push(8'h33);
      chk("word_stall3", {31'b0, in_stall}, 32'd1);
      chk("word_data3", in_data, 32'd0);
      rx_push(8'h44);
      chk("word_stall4", {31'b0, in_stall}, 32'd0);
      chk("word_data4", in_data, 32'h4433_2211);
      in_issued = 1'b1;
      step();
      chk("word_popped", {31'b0, in_stall}, 32'd1);

      // TX fill with tx_ready low: 64 in the FIFO plus one in the holding register.
      tx_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 66; i++) begin
         if (!out_stall) accepted++;
         do_out(32'hABCD_0000 | 32'(i));
      end
      chk("fill_accepted", 32'(accepted), 32'd65);
      chk("fill_stall", {31'b0, out_stall}, 32'd1);
      chk("fill_hold", {23'b0, tx_valid, tx_byte}, 32'h0000_0100);
      tx_ready = 1'b1;
      step();
      chk("fill_unstall", {31'b0, out_stall}, 32'd0);
      chk("fill_next", {24'b0, tx_byte}, 32'h0000_0001);

      // Partial drain plus some RX traffic, then an asynchronous reset mid-transfer.
      for (int i = 0; i < 30; i++) begin
         if (i < 3) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'hC0 + i);
         end
         step();
      end
      tx_ready = 1'b0;
      chk("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("midrst");
      #4 rst = 1'b0;
      step();

      // RX overflow, then a push at full alongside an IN pop must not drop.
      for (int i = 0; i < RXD; i++) rx_push(8'(i));
      chk("ovf_full_data", in_data, 32'h0302_0100);
      chk("ovf_before", {31'b0, rx_overflow}, 32'd0);
      rx_push(8'hFF);
      chk("ovf_set", {31'b0, rx_overflow}, 32'd1);
      chk("ovf_dropped", in_data, 32'h0302_0100);
      rx_valid  = 1'b1;
      rx_byte   = 8'hEE;
      in_issued = 1'b1;
      step();
      chk("full_pop_data", in_data, 32'h0706_0504);
      for (int i = 0; i < 15; i++) begin
         in_issued = 1'b1;
         step();
      end
      chk("tail_stall", {31'b0, in_stall}, 32'd1);
      rx_push(8'hA1);
      rx_push(8'hA2);
      rx_push(8'hA3);
      chk("tail_kept", in_data, 32'hA3A2_A1EE);
      in_issued = 1'b1;
      step();
      chk("ovf_sticky", {31'b0, rx_overflow}, 32'd1);

`ifdef IO_CTRL_LOOPBACK_EN
      loopback = 1'b1;
      tx_ready = 1'b1;
      do_out(32'h0000_005A);
      rx_valid = 1'b1;
      rx_byte  = 8'h99;
      do_out(32'h0000_005B);
      do_out(32'h0000_005C);
      chk("lb_stall3", {31'b0, in_stall}, 32'd1);
      do_out(32'h0000_005D);
      chk("lb_data", in_data, 32'h5D5C_5B5A);
      chk("lb_tx_idle", {31'b0, tx_valid}, 32'd0);
      in_issued = 1'b1;
      step();
      chk("lb_popped", {31'b0, in_stall}, 32'd1);
      loopback = 1'b0;
      step();
`endif

      step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
